// File: rtl/alu_sequencer_if.sv
// Instruction-ROM and ALU-facing bus of the sequencer.
// The master side is the sequencer; the slave side is the ROM/ALU pair.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic [2:0]      alu_a_addr;
    logic [2:0]      alu_b_addr;
    logic [7:0]      alu_const;
    logic [2:0]      alu_op;
    logic            alu_cin;
    logic            alu_we;
    logic            alu_cout;
    logic            alu_ovf;
    logic            alu_zero;
    logic            alu_neg;

    modport master (
        output imem_addr, alu_a_addr, alu_b_addr, alu_const, alu_op, alu_cin, alu_we,
        input  imem_data, alu_cout, alu_ovf, alu_zero, alu_neg
    );

    modport slave (
        input  imem_addr, alu_a_addr, alu_b_addr, alu_const, alu_op, alu_cin, alu_we,
        output imem_data, alu_cout, alu_ovf, alu_zero, alu_neg
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 8-register ALU, one instruction in flight.
// ALU/MOVI take 4 cycles fetch-to-fetch, branches 3; start is only honoured in IDLE/HALT.
module alu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    alu_sequencer_if.master bus,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic            is_br;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic            c_f, v_f, z_f, n_f;
    logic            taken;
    logic [1:0]      cls;

    assign bus.imem_addr = pc;
    assign cls           = bus.imem_data[15:14];

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = z_f;
            3'b010:  taken = ~z_f;
            3'b011:  taken = c_f;
            3'b100:  taken = n_f;
            3'b101:  taken = v_f;
            3'b110:  taken = ~c_f;
            default: taken = ~n_f;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            is_br          <= 1'b0;
            br_cond        <= 3'b000;
            br_target      <= '0;
            {c_f, v_f, z_f, n_f} <= 4'b0000;
            bus.alu_a_addr <= 3'b000;
            bus.alu_b_addr <= 3'b000;
            bus.alu_const  <= 8'h00;
            bus.alu_op     <= 3'b000;
            bus.alu_cin    <= 1'b0;
            bus.alu_we     <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state  <= FETCH;
                        pc     <= RESET_PC;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    // ALU fields decode straight from ROM data so they are registered on entry to EXEC
                    is_br     <= (cls == 2'b10);
                    br_cond   <= bus.imem_data[13:11];
                    br_target <= bus.imem_data[PC_W-1:0];
                    case (cls)
                        2'b00: begin
                            bus.alu_op     <= bus.imem_data[13:11];
                            bus.alu_a_addr <= bus.imem_data[10:8];
                            bus.alu_b_addr <= bus.imem_data[7:5];
                            bus.alu_cin    <= bus.imem_data[4] & c_f;
                            bus.alu_we     <= 1'b1;
                            state          <= EXEC;
                        end
                        2'b01: begin
                            bus.alu_op     <= 3'b000;
                            bus.alu_a_addr <= bus.imem_data[10:8];
                            bus.alu_const  <= bus.imem_data[7:0];
                            bus.alu_cin    <= 1'b0;
                            bus.alu_we     <= 1'b1;
                            state          <= EXEC;
                        end
                        2'b10: state <= EXEC;
                        default: begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    if (is_br) begin
                        pc    <= taken ? br_target : pc + PC_ONE;
                        state <= FETCH;
                    end else begin
                        bus.alu_we <= 1'b0;
                        state      <= WB;
                    end
                end
                WB: begin
                    {c_f, v_f, z_f, n_f} <= {bus.alu_cout, bus.alu_ovf, bus.alu_zero, bus.alu_neg};
                    pc    <= pc + PC_ONE;
                    state <= FETCH;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end
endmodule
